// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the program counter, drives the
// instruction memory word address, and buffers fetched words with their PCs
// in a small in-order queue that feeds decode through a valid/ready handshake.
// Redirects load a new PC and flush the queue. Reset clears all queued state.
module fetch_queue_unit #(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 6,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [PC_W-1:0]            out_pc_plus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]  r_pc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_instr    [DEPTH];
  logic [PC_W-1:0]  r_entry_pc [DEPTH];
  // Last head shown to decode, so out_* hold steady while the queue is empty.
  logic [31:0]      r_last_instr;
  logic [PC_W-1:0]  r_last_pc;

  logic             w_pop;
  logic             w_space;
  logic             w_push;
  logic [PC_W-1:0]  w_redirect_target;
  logic [31:0]      w_head_instr;
  logic [PC_W-1:0]  w_head_pc;

  // Handshake and queue control decisions for this cycle.
  always_comb begin
    w_pop             = out_valid & out_ready;
    // A full queue can still accept a word in the same cycle the head leaves.
    w_space           = (r_count < FULL_CNT) | w_pop;
    w_push            = fetch_en & w_space & ~redirect_valid;
    // The low two bits of the target are dropped to keep word alignment.
    w_redirect_target = redirect_pc & ~PC_W'(3);
    w_head_instr      = r_instr[r_rd_ptr];
    w_head_pc         = r_entry_pc[r_rd_ptr];
  end

  // Output view: live head when valid, otherwise the last head presented.
  always_comb begin
    imem_addr    = r_pc[ADDR_W+1:2];
    out_valid    = (r_count != '0);
    out_instr    = out_valid ? w_head_instr : r_last_instr;
    out_pc       = out_valid ? w_head_pc : r_last_pc;
    out_pc_plus4 = out_pc + PC_W'(4);
    count        = r_count;
  end

  // Program counter: reset wins, then redirect, then sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_push) begin
      r_pc <= r_pc + PC_W'(4);
    end
  end

  // Pointers and occupancy; a redirect drops everything not popped this cycle.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Entry storage: capture the fetched word together with the PC it came from.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i]    <= '0;
        r_entry_pc[i] <= '0;
      end
    end else if (w_push) begin
      r_instr[r_wr_ptr]    <= imem_data;
      r_entry_pc[r_wr_ptr] <= r_pc;
    end
  end

  // Remember the head currently on display for the empty-queue hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else if (out_valid) begin
      r_last_instr <= w_head_instr;
      r_last_pc    <= w_head_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: directed scenario tasks plus a scoreboard
// monitor that predicts every push and checks every delivered head.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [1:0]  count;

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;
  bit mon_en      = 1'b0;

  // Reference state: expected queue contents {instr, pc} and expected PC.
  logic [63:0] sb[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  // Instruction memory: word i holds 32'h1000_0000 + i.
  assign imem_data = 32'h1000_0000 + {26'b0, imem_addr};

  fetch_queue_unit #(
    .PC_W(32), .ADDR_W(6), .DEPTH(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .count(count)
  );

  // Scoreboard monitor: compares at the falling edge, then predicts the next rising edge.
  always @(negedge clk) begin : monitor
    logic        pop_e;
    logic        push_e;
    logic [63:0] e;
    if (mon_en) begin
      vectors++;
      if (imem_addr !== m_pc[7:2]) begin
        miscompares++;
        $display("FAIL sb_imem_addr: got %0d want %0d", imem_addr, m_pc[7:2]);
      end
      vectors++;
      if (out_valid !== (sb.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_out_valid: got %b want %0d", out_valid, sb.size() != 0);
      end
      vectors++;
      if (count !== sb.size()) begin
        miscompares++;
        $display("FAIL sb_count: got %0d want %0d", count, sb.size());
      end
      pop_e = (sb.size() != 0) && (out_ready === 1'b1);
      if (pop_e) begin
        e = sb[0];
        delivered++;
        vectors++;
        if (out_instr !== e[63:32] || out_pc !== e[31:0] || out_pc_plus4 !== e[31:0] + 32'd4) begin
          miscompares++;
          $display("FAIL sb_head: got instr=%h pc=%h pc4=%h want instr=%h pc=%h pc4=%h",
                   out_instr, out_pc, out_pc_plus4, e[63:32], e[31:0], e[31:0] + 32'd4);
        end
      end
      if (reset) begin
        sb.delete();
        m_pc = 32'h0;
      end else if (redirect_valid) begin
        sb.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        push_e = fetch_en && ((sb.size() < 2) || pop_e);
        if (pop_e) void'(sb.pop_front());
        if (push_e) begin
          sb.push_back({32'h1000_0000 + {26'b0, m_pc[7:2]}, m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0 || imem_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got count=%0d valid=%b addr=%0d want 0 0 0", count, out_valid, imem_addr);
    end
    vectors++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_data: got instr=%h pc=%h pc4=%h want 0 0 4", out_instr, out_pc, out_pc_plus4);
    end
    reset = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_first_cycle_valid: got %b want 0", out_valid);
    end
    tick(1);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'h1000_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL seq_word%0d: got valid=%b pc=%h instr=%h want 1 %h %h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), 32'h1000_0000 + 32'(i));
      end
      tick(1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(5);
    vectors++;
    if (count !== 2'd2 || imem_addr !== 6'd2 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL bp_full: got count=%0d addr=%0d head=%h want 2 2 0", count, imem_addr, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL bp_release%0d: got valid=%b pc=%h want 1 %h", i, out_valid, out_pc, 32'(4 * i));
      end
      tick(1);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042; out_ready = 1'b1;
    vectors++;
    if (count !== 2'd2 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL redir_pre: got count=%0d head=%h want 2 0", count, out_pc);
    end
    tick(1);
    redirect_valid = 1'b0;
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0 || imem_addr !== 6'h10) begin
      miscompares++;
      $display("FAIL redir_flush: got count=%0d valid=%b addr=%h want 0 0 10", count, out_valid, imem_addr);
    end
    tick(1);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h1000_0010) begin
      miscompares++;
      $display("FAIL redir_target: got valid=%b pc=%h instr=%h want 1 40 10000010", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_00FC;
    tick(1);
    redirect_valid = 1'b0;
    vectors++;
    if (imem_addr !== 6'd63) begin
      miscompares++;
      $display("FAIL wrap_addr63: got %0d want 63", imem_addr);
    end
    fetch_en = 1'b1;
    tick(1);
    vectors++;
    if (imem_addr !== 6'd0 || out_pc !== 32'hFC || out_instr !== 32'h1000_003F) begin
      miscompares++;
      $display("FAIL wrap_fc: got addr=%0d pc=%h instr=%h want 0 fc 1000003f", imem_addr, out_pc, out_instr);
    end
    tick(1);
    vectors++;
    if (out_pc !== 32'h100 || out_instr !== 32'h1000_0000 || out_pc_plus4 !== 32'h104) begin
      miscompares++;
      $display("FAIL wrap_100: got pc=%h instr=%h pc4=%h want 100 10000000 104", out_pc, out_instr, out_pc_plus4);
    end
  endtask

  task automatic test_fetch_gate();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    tick(3);
    fetch_en = 1'b0;
    tick(3);
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0 || imem_addr !== 6'd3) begin
      miscompares++;
      $display("FAIL gate_drain: got count=%0d valid=%b addr=%0d want 0 0 3", count, out_valid, imem_addr);
    end
    fetch_en = 1'b1;
    tick(1);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC) begin
      miscompares++;
      $display("FAIL gate_resume: got valid=%b pc=%h want 1 c", out_valid, out_pc);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(2);
    vectors++;
    if (count !== 2'd2) begin
      miscompares++;
      $display("FAIL midrst_pre: got count=%0d want 2", count);
    end
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick(1);
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0 || imem_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL midrst_post: got count=%0d valid=%b addr=%0d want 0 0 0", count, out_valid, imem_addr);
    end
    tick(1);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_restart: got valid=%b pc=%h want 1 0", out_valid, out_pc);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    start = delivered;
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      reset          = ($urandom_range(0, 60) == 0);
      tick(1);
    end
    reset = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    tick(4);
    vectors++;
    if (delivered - start < 100) begin
      miscompares++;
      $display("FAIL b2b_throughput: got %0d deliveries want at least 100", delivered - start);
    end
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    m_pc = 32'h0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_addr_wrap();
    test_fetch_gate();
    test_mid_reset();
    test_back_to_back();
    fetch_en = 1'b0; out_ready = 1'b0;
    tick(1);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end directly upstream of the 64-word combinational instruction memory, and its sole address driver.
- Holds the program counter and drives the word address; memory data returns in the same cycle.
- Captures each fetched word with its PC into a small in-order queue.
- Presents the queue head to decode over a valid/ready handshake; supports stall via backpressure, fetch gating and redirect (branch/jump) with flush.

Parameters:
- PC_W, 32, program counter width in bits.
- ADDR_W, 6, instruction memory word-address width.
- DEPTH, 2, queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  enables fetching; when low, PC holds and no push occurs.
- redirect_valid  input  1  one-cycle request to load a new PC and flush the queue.
- redirect_pc  input  PC_W  redirect target; bits [1:0] are ignored and forced to 0.
- imem_addr  output  ADDR_W  word address to instruction memory, equal to pc[ADDR_W+1:2].
- imem_data  input  32  instruction word, combinational from imem_addr.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  PC_W  PC of the head instruction.
- out_pc_plus4  output  PC_W  out_pc + 4, modulo 2^PC_W.
- count  output  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (reset=1 at a rising edge), regardless of other inputs:
  - pc = RESET_PC; count = 0; all entry storage = 0.
  - Read and write pointers = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0; out_pc_plus4 = 4.
- Reset mid-operation discards all queued entries and any concurrent redirect.
- imem_addr is combinational from the pc register. PC bits above ADDR_W+1 do not reach memory, so the address wraps modulo 2^ADDR_W words.
- pop = out_valid & out_ready.
- space = (count < DEPTH) | pop. A full queue may push in the same cycle it pops.
- push = fetch_en & space & ~redirect_valid.
- On push:
  - Entry {imem_data, pc} is written at the write pointer.
  - pc <= pc + 4, wrapping at 2^PC_W.
  - The fetched word appears at out_* one cycle later at the earliest (queue was empty).
- On pop: the read pointer advances. Entries are delivered strictly in push order.
- count update: count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
- Redirect (redirect_valid=1, reset=0):
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}.
  - count <= 0 and both pointers <= 0. No push occurs that cycle.
  - out_valid is not masked in the redirect cycle: if pop=1, that head transfer counts as delivered; all other entries are dropped.
  - The first instruction from the target appears at out_* two cycles after the redirect edge, provided fetch_en=1.
- Empty queue: out_valid = 0; out_instr, out_pc and out_pc_plus4 hold their last values (don't-care to decode). A pop is impossible while empty.
- Full queue (count == DEPTH) with out_ready = 0: no push, and PC holds.
- fetch_en = 0: PC holds, no push; pops continue normally.
- out_* come from registered storage; there is no combinational path from imem_data to out_*.
- Throughput: one instruction per cycle when out_ready stays high.

Test Plan:
- Sequential fetch: memory word i = 32'h1000_0000+i, fetch_en=1, out_ready=1 after reset → out_valid rises on cycle 2; out_pc = 0, 4, 8, … with out_instr = 32'h1000_0000, _0001, _0002, …, one per cycle, no gaps.
- Backpressure: out_ready=0 for 5 cycles → count saturates at 2 and pc holds at 8. On release, PCs 0, 4, 8, 12 emerge in order with no loss or duplication.
- Redirect with full queue: redirect_pc=32'h0000_0042 while count=2 and out_ready=1 → head PC delivered that cycle, second entry dropped; the next valid output is out_pc=32'h40 two cycles later.
- Address wrap: redirect to 32'h0000_00FC, then 32'h0000_0100 → imem_addr = 63 then 0; out_pc = 32'hFC then 32'h100.
- fetch_en gating: fetch_en=0 for 3 cycles with out_ready=1 → queue drains to count=0, out_valid=0, pc unchanged; resumes at the same PC.
- Mid-run reset: reset for 1 cycle while count=2 and redirect_valid=1 → next cycle count=0, out_valid=0, imem_addr=0; the redirect is ignored.
